// File: rtl/trace_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module     : trace_byte_streamer
// Purpose    : Captures {PC, result} debug pairs into a FIFO and serialises
//              each pair as a 9-byte frame (sync, PC, result) on an 8-bit
//              valid/ready port.
// Revision   : 1.0 - initial release
// ============================================================================
module trace_byte_streamer #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              result_in,
    input  logic                     capture,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int                 c_ADDR_W     = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]  c_FULL_LEVEL = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]         c_LAST_IDX   = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [63:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wr_ptr;
    logic [c_ADDR_W-1:0]  r_rd_ptr;
    logic [c_ADDR_W:0]    r_level;

    state_t               r_state;
    logic [3:0]           r_idx;
    logic [63:0]          r_shift;
    logic [7:0]           r_byte_out;
    logic                 r_byte_valid;
    logic                 r_overflow;
    logic [7:0]           r_drop_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_xfer;
    logic [63:0]          w_head;
    state_t               w_state_nxt;
    logic [3:0]           w_idx_nxt;
    logic [63:0]          w_shift_nxt;
    logic                 w_valid_nxt;
    logic [7:0]           w_byte_nxt;

    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);
    // Full is judged on the current level, so a same-cycle pop cannot rescue a capture.
    assign w_wr    = capture & ~w_full;
    assign w_xfer  = r_byte_valid & byte_ready;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset && w_wr) begin
            r_mem[r_wr_ptr] <= {pc_in, result_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'h00;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (c_ADDR_W + 1)'(1);
                2'b01:   r_level <= r_level - (c_ADDR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (capture && w_full) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_shift      <= 64'd0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_out   <= w_byte_nxt;
            r_byte_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt = 4'd0;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_head;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                        // The sync byte does not consume payload, so the PC MSB stays on top.
                        if (r_idx != 4'd0) begin
                            w_shift_nxt = {r_shift[55:0], 8'h00};
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_valid_nxt = (w_state_nxt == ST_SEND);
        if (!w_valid_nxt) begin
            w_byte_nxt = 8'h00;
        end else if (w_idx_nxt == 4'd0) begin
            w_byte_nxt = SYNC_BYTE;
        end else begin
            w_byte_nxt = w_shift_nxt[63:56];
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_trace_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module     : tb_trace_byte_streamer
// Purpose    : Directed self-checking bench for trace_byte_streamer.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_trace_byte_streamer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] result_in;
    logic        capture;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] got [0:63];
    int         got_n;
    int         stab_err;
    int         gap_cnt;

    always #5 clk = ~clk;

    trace_byte_streamer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .result_in  (result_in),
        .capture    (capture),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    function automatic logic [7:0] frame_byte(input logic [31:0] pc, input logic [31:0] res, input int j);
        logic [63:0] e;
        e = {pc, res};
        if (j == 0) return 8'hA5;
        return e[63 - 8*(j-1) -: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        capture = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // mode 0: ready held high; mode 1: ready toggles 1,0,1,0...
    task automatic collect(input int n, input int mode, input int budget);
        logic [7:0] pb;
        logic       pv, pr;
        int         cyc;
        bit         started;
        cyc = 0; started = 0; pv = 1'b0; pr = 1'b1; pb = 8'h00;
        got_n = 0; stab_err = 0; gap_cnt = 0;
        while (got_n < n && cyc < budget) begin
            byte_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            if (pv && !pr && (byte_valid !== 1'b1 || byte_out !== pb)) stab_err++;
            if (byte_valid === 1'b1) started = 1;
            else if (started) gap_cnt++;
            if (byte_valid === 1'b1 && byte_ready) begin
                got[got_n] = byte_out;
                got_n++;
            end
            pv = byte_valid; pb = byte_out; pr = byte_ready;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        byte_ready = 1'b1;
        pc_in = 32'h0; result_in = 32'h0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            n_cmp += 5;
            if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d got %b want 0", c, byte_valid); end
            if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte cyc%0d got %h want 00", c, byte_out); end
            if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow cyc%0d got %b want 0", c, overflow); end
            if (drop_count !== 8'h00) begin n_fail++; $display("FAIL reset_drop cyc%0d got %h want 00", c, drop_count); end
            if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level cyc%0d got %0d want 0", c, fifo_level); end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        byte_ready = 1'b1;
        pc_in = 32'h0000_0010; result_in = 32'hDEAD_BEEF; capture = 1'b1;
        tick();
        capture = 1'b0;
        n_cmp += 2;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", byte_valid); end
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level_after_write got %0d want 1", fifo_level); end
        tick();
        n_cmp += 3;
        if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency_valid got %b want 1", byte_valid); end
        if (byte_out !== 8'hA5) begin n_fail++; $display("FAIL single_latency_byte got %h want a5", byte_out); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level_after_pop got %0d want 0", fifo_level); end
        collect(9, 0, 20);
        n_cmp += 2;
        if (got_n !== 9) begin n_fail++; $display("FAIL single_count got %0d want 9", got_n); end
        if (gap_cnt !== 0) begin n_fail++; $display("FAIL single_gaps got %0d want 0", gap_cnt); end
        for (int j = 0; j < got_n; j++) begin
            n_cmp++;
            if (got[j] !== frame_byte(32'h0000_0010, 32'hDEAD_BEEF, j)) begin
                n_fail++;
                $display("FAIL single_byte%0d got %h want %h", j, got[j], frame_byte(32'h0000_0010, 32'hDEAD_BEEF, j));
            end
        end
        n_cmp += 2;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid got %b want 0", byte_valid); end
        if (byte_out !== 8'h00) begin n_fail++; $display("FAIL single_end_byte got %h want 00", byte_out); end
    endtask

    task automatic test_backpressure();
        do_reset();
        byte_ready = 1'b1;
        pc_in = 32'h0000_0010; result_in = 32'hDEAD_BEEF; capture = 1'b1;
        tick();
        capture = 1'b0;
        collect(9, 1, 40);
        n_cmp += 2;
        if (got_n !== 9) begin n_fail++; $display("FAIL bp_count got %0d want 9", got_n); end
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stability got %0d unstable cycles want 0", stab_err); end
        for (int j = 0; j < got_n; j++) begin
            n_cmp++;
            if (got[j] !== frame_byte(32'h0000_0010, 32'hDEAD_BEEF, j)) begin
                n_fail++;
                $display("FAIL bp_byte%0d got %h want %h", j, got[j], frame_byte(32'h0000_0010, 32'hDEAD_BEEF, j));
            end
        end
    endtask

    task automatic test_overflow();
        int max_lvl;
        do_reset();
        byte_ready = 1'b0;
        max_lvl = 0;
        for (int i = 0; i < 6; i++) begin
            pc_in = 32'h0000_1000 + 32'(i*4);
            result_in = 32'hA0B0_C0D0 ^ 32'(i);
            capture = 1'b1;
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
        capture = 1'b0;
        n_cmp += 4;
        if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        if (max_lvl !== 4) begin n_fail++; $display("FAIL ovf_max_level got %0d want 4", max_lvl); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        if (drop_count !== 8'd1) begin n_fail++; $display("FAIL ovf_drop got %0d want 1", drop_count); end
        collect(45, 0, 80);
        n_cmp += 3;
        if (got_n !== 45) begin n_fail++; $display("FAIL ovf_count got %0d want 45", got_n); end
        if (gap_cnt !== 0) begin n_fail++; $display("FAIL ovf_gaps got %0d want 0", gap_cnt); end
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_end_valid got %b want 0 (6th frame present)", byte_valid); end
        for (int j = 0; j < got_n; j++) begin
            logic [7:0] e;
            e = frame_byte(32'h0000_1000 + 32'((j/9)*4), 32'hA0B0_C0D0 ^ 32'(j/9), j % 9);
            n_cmp++;
            if (got[j] !== e) begin n_fail++; $display("FAIL ovf_byte%0d got %h want %h", j, got[j], e); end
        end
    endtask

    task automatic test_saturate();
        bit   wrapped;
        logic [7:0] prev;
        do_reset();
        byte_ready = 1'b0;
        wrapped = 0; prev = 8'h00;
        for (int i = 0; i < 300; i++) begin
            pc_in = 32'(i); result_in = ~32'(i);
            capture = 1'b1;
            tick();
            if (drop_count < prev) wrapped = 1;
            prev = drop_count;
        end
        capture = 1'b0;
        n_cmp += 3;
        if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL sat_drop got %h want ff", drop_count); end
        if (wrapped !== 1'b0) begin n_fail++; $display("FAIL sat_wrap got %b want 0", wrapped); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b want 1", overflow); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h1122_3344 + 32'(i); result_in = 32'h5566_7788; capture = 1'b1;
            tick();
        end
        capture = 1'b0;
        tick();
        tick();
        n_cmp += 2;
        if (byte_out !== 8'h33) begin n_fail++; $display("FAIL mid_idx3_byte got %h want 33", byte_out); end
        if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL mid_level got %0d want 2", fifo_level); end
        reset = 1'b0;
        tick();
        n_cmp += 3;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", byte_valid); end
        if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_byte got %h want 00", byte_out); end
        if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_resume got valid %b want 0", byte_valid); end
        pc_in = 32'hCAFE_F00D; result_in = 32'h0123_4567; capture = 1'b1;
        tick();
        capture = 1'b0;
        collect(9, 0, 20);
        n_cmp++;
        if (got_n !== 9) begin n_fail++; $display("FAIL mid_count got %0d want 9", got_n); end
        for (int j = 0; j < got_n; j++) begin
            n_cmp++;
            if (got[j] !== frame_byte(32'hCAFE_F00D, 32'h0123_4567, j)) begin
                n_fail++;
                $display("FAIL mid_byte%0d got %h want %h", j, got[j], frame_byte(32'hCAFE_F00D, 32'h0123_4567, j));
            end
        end
    endtask

    initial begin
        reset = 1'b0; capture = 1'b0; byte_ready = 1'b1;
        pc_in = 32'h0; result_in = 32'h0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_saturate();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
